// File: rtl/mem_req_ctrl.sv
// Memory request controller: clears the memory after reset, then forwards
// read/write requests to a single-port synchronous memory and returns read
// data through a 3-entry in-order response FIFO.
module mem_req_ctrl #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned MEM_DEPTH  = 256,
    parameter int unsigned WORD_BYTES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [8*WORD_BYTES-1:0] req_wdata,
    input  logic [WORD_BYTES-1:0]   req_be,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [8*WORD_BYTES-1:0] rsp_data,
    output logic                    rsp_err,
    output logic                    init_done,
    output logic                    mem_ce,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [8*WORD_BYTES-1:0] mem_wr_data,
    output logic [WORD_BYTES-1:0]   mem_be,
    input  logic [8*WORD_BYTES-1:0] mem_rd_data
);

    localparam int unsigned DataW = 8 * WORD_BYTES;
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [1:0] FifoLast = 2'd2;

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_addr_q;
    logic                  infl_q, infl_err_q;
    logic [1:0]            count_q, count_d;
    logic [1:0]            rd_ptr_q, wr_ptr_q;
    logic [DataW-1:0]      fifo_data_q [0:2];
    logic                  fifo_err_q  [0:2];

    logic       in_range;
    logic       accept;
    logic       push;
    logic       pop;
    logic [2:0] occupancy;

    assign in_range  = 32'(req_addr) < MEM_DEPTH;
    assign accept    = req_valid & req_ready;
    assign push      = infl_q;
    assign pop       = rsp_valid & rsp_ready;
    // The in-flight read already owns a FIFO slot, so it counts toward the limit.
    assign occupancy = {1'b0, count_q} + {2'b00, infl_q};

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: leave INIT once the last word has been cleared
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:  if (init_addr_q == LastAddr) state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StInit;
        endcase
    end

    // FSM outputs: memory port, request handshake and init status
    always_comb begin
        req_ready   = 1'b0;
        init_done   = 1'b0;
        mem_ce      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_be      = '0;
        unique case (state_q)
            StInit: begin
                if (rst_n) begin
                    mem_ce   = 1'b1;
                    mem_we   = 1'b1;
                    mem_addr = init_addr_q;
                    mem_be   = '1;
                end
            end
            StRun: begin
                init_done = 1'b1;
                req_ready = occupancy <= 3'd2;
                // Out-of-range requests are accepted but never reach the memory.
                if (rst_n && req_valid && req_ready && in_range) begin
                    mem_ce      = 1'b1;
                    mem_we      = req_we;
                    mem_addr    = req_addr;
                    mem_wr_data = req_wdata;
                    mem_be      = req_be;
                end
            end
            default: ;
        endcase
    end

    // FIFO occupancy next state; simultaneous push and pop cancel out
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Control registers: init address, in-flight read, FIFO pointers and count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            init_addr_q <= '0;
            infl_q      <= 1'b0;
            infl_err_q  <= 1'b0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
        end else begin
            if (state_q == StInit) begin
                init_addr_q <= init_addr_q + ADDR_WIDTH'(1);
            end
            infl_q     <= accept & ~req_we;
            infl_err_q <= accept & ~req_we & ~in_range;
            count_q    <= count_d;
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == FifoLast) ? 2'd0 : wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == FifoLast) ? 2'd0 : rd_ptr_q + 2'd1;
            end
        end
    end

    // FIFO storage: memory data arrives the cycle after the read was accepted
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            fifo_data_q[wr_ptr_q] <= infl_err_q ? '0 : mem_rd_data;
            fifo_err_q[wr_ptr_q]  <= infl_err_q;
        end
    end

    // Response outputs show the FIFO head, forced to zero when empty
    always_comb begin
        rsp_valid = count_q != 2'd0;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        if (rsp_valid) begin
            rsp_data = fifo_data_q[rd_ptr_q];
            rsp_err  = fifo_err_q[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with a synchronous memory model and a
// response scoreboard (expected reads queued at acceptance, popped on handshake).
module tb_mem_req_ctrl;

    typedef struct packed {
        logic [15:0] data;
        logic        err;
    } rsp_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        init_done;
    logic        mem_ce;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [15:0] mem_wr_data;
    logic [1:0]  mem_be;
    logic [15:0] mem_rd_data;

    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    rsp_t exp_q[$];

    logic [15:0] ram   [0:15];
    logic [15:0] model [0:15];

    mem_req_ctrl #(
        .ADDR_WIDTH (4),
        .MEM_DEPTH  (10),
        .WORD_BYTES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_be      (req_be),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .init_done   (init_done),
        .mem_ce      (mem_ce),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_be      (mem_be),
        .mem_rd_data (mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory with byte enables; junk contents expose a missing clear.
    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 16'hDEAD;
        mem_rd_data = 16'h0;
    end

    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) begin
                for (int b = 0; b < 2; b++) begin
                    if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wr_data[8*b +: 8];
                end
            end else begin
                mem_rd_data <= ram[mem_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Response monitor: samples 1 time unit after the falling edge, i.e. the
    // values the next rising edge will see.
    always begin
        rsp_t e;
        @(negedge clk);
        #1;
        if (mon_en && rst_n) begin
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected_pending", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_data", 64'(rsp_data), 64'(e.data));
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                end
            end else if (!rsp_valid) begin
                chk("empty_rsp_data", 64'(rsp_data), 64'd0);
                chk("empty_rsp_err", 64'(rsp_err), 64'd0);
            end
        end
    end

    // Called at a falling edge with rst_n just released.
    task automatic init_seq();
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("init_mem_ce", 64'(mem_ce), 64'd1);
            chk("init_mem_we", 64'(mem_we), 64'd1);
            chk("init_mem_addr", 64'(mem_addr), 64'(i));
            chk("init_mem_wr_data", 64'(mem_wr_data), 64'd0);
            chk("init_mem_be", 64'(mem_be), 64'd3);
            chk("init_req_ready", 64'(req_ready), 64'd0);
            chk("init_done_low", 64'(init_done), 64'd0);
            @(negedge clk);
        end
        #1;
        chk("init_done_high", 64'(init_done), 64'd1);
        chk("run_req_ready", 64'(req_ready), 64'd1);
        chk("run_idle_mem_ce", 64'(mem_ce), 64'd0);
        for (int i = 0; i < 16; i++) model[i] = 16'h0;
        @(negedge clk);
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input logic we, input logic [3:0] addr, input logic [15:0] wd,
                         input logic [1:0] be, input bit expect_now);
        int   n = 0;
        logic inr;
        rsp_t e;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        #1;
        while (!req_ready && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("req_ready_accept", 64'(req_ready), 64'd1);
        if (expect_now) chk("req_ready_no_stall", 64'(n), 64'd0);
        inr = addr < 4'd10;
        chk("req_mem_ce", 64'(mem_ce), 64'(inr));
        if (inr) begin
            chk("req_mem_we", 64'(mem_we), 64'(we));
            chk("req_mem_addr", 64'(mem_addr), 64'(addr));
            chk("req_mem_wr_data", 64'(mem_wr_data), 64'(wd));
            chk("req_mem_be", 64'(mem_be), 64'(be));
        end
        if (we) begin
            if (inr) begin
                for (int b = 0; b < 2; b++) begin
                    if (be[b]) model[addr][8*b +: 8] = wd[8*b +: 8];
                end
            end
        end else begin
            e.data = inr ? model[addr] : 16'h0;
            e.err  = ~inr;
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 4'h0;
        req_wdata = 16'h0;
        req_be    = 2'b00;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("drain_scoreboard_empty", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        idle();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_ce", 64'(mem_ce), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);

        // Memory clear
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        init_seq();

        // Partial-byte write then read back; response on the second edge
        // counting the accepting edge
        rsp_ready = 1'b1;
        issue(1'b1, 4'd3, 16'hA5C3, 2'b01, 1'b1);
        issue(1'b0, 4'd3, 16'h0000, 2'b00, 1'b1);
        idle();
        #1;
        chk("lat_valid_edge1", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        #1;
        chk("lat_valid_edge2", 64'(rsp_valid), 64'd1);
        chk("lat_data", 64'(rsp_data), 64'h00C3);
        chk("lat_err", 64'(rsp_err), 64'd0);
        drain();

        // Back-to-back reads with rsp_ready held high
        issue(1'b0, 4'd0, 16'h0, 2'b00, 1'b1);
        issue(1'b0, 4'd1, 16'h0, 2'b00, 1'b1);
        issue(1'b0, 4'd2, 16'h0, 2'b00, 1'b1);
        idle();
        #1;
        chk("b2b_valid_a", 64'(rsp_valid), 64'd1);
        @(negedge clk);
        #1;
        chk("b2b_valid_b", 64'(rsp_valid), 64'd1);
        @(negedge clk);
        #1;
        chk("b2b_valid_c", 64'(rsp_valid), 64'd0);
        #1;
        chk("b2b_scoreboard_empty", 64'(exp_q.size()), 64'd0);
        @(negedge clk);

        // Backpressure: FIFO fills, head holds, then drains in order
        for (int k = 4; k < 8; k++) begin
            issue(1'b1, 4'(k), 16'h1111 * 16'(k), 2'b11, 1'b1);
        end
        rsp_ready = 1'b0;
        issue(1'b0, 4'd4, 16'h0, 2'b00, 1'b1);
        issue(1'b0, 4'd5, 16'h0, 2'b00, 1'b1);
        issue(1'b0, 4'd6, 16'h0, 2'b00, 1'b1);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'd7;
        #1;
        chk("full_req_ready_a", 64'(req_ready), 64'd0);
        chk("full_mem_ce", 64'(mem_ce), 64'd0);
        chk("hold_valid_a", 64'(rsp_valid), 64'd1);
        chk("hold_data_a", 64'(rsp_data), 64'(model[4]));
        @(negedge clk);
        #1;
        chk("full_req_ready_b", 64'(req_ready), 64'd0);
        chk("hold_data_b", 64'(rsp_data), 64'(model[4]));
        @(negedge clk);
        rsp_ready = 1'b1;
        issue(1'b0, 4'd7, 16'h0, 2'b00, 1'b0);
        idle();
        drain();

        // Out-of-range read and write
        issue(1'b0, 4'd12, 16'h0, 2'b00, 1'b1);
        issue(1'b1, 4'd15, 16'hFFFF, 2'b11, 1'b1);
        idle();
        drain();

        // Reset with two responses buffered
        rsp_ready = 1'b0;
        issue(1'b0, 4'd5, 16'h0, 2'b00, 1'b1);
        issue(1'b0, 4'd6, 16'h0, 2'b00, 1'b1);
        idle();
        @(negedge clk);
        #1;
        chk("pre_rst_valid", 64'(rsp_valid), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        #1;
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("mid_rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("mid_rst_init_done", 64'(init_done), 64'd0);
        chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
        chk("mid_rst_mem_ce", 64'(mem_ce), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        init_seq();

        // Word written earlier must read back cleared
        issue(1'b0, 4'd3, 16'h0, 2'b00, 1'b1);
        idle();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
